// File: rtl/hough_peak_reader.sv
// Scans the Hough accumulator in ZBT memory and streams bins at or above threshold.
// Optional HOUGH_READER_CLEAR_EN: zero each bin in the cycle after it is read.
module hough_peak_reader #(
  parameter int FIFO_DEPTH  = 8,
  parameter int MEM_LATENCY = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [35:0]        threshold,
  output logic               busy,
  output logic               done,
  output logic [18:0]        mem_addr,
  input  logic [35:0]        mem_read_data,
  output logic [35:0]        mem_write_data,
  output logic               mem_we,
  output logic               peak_valid,
  input  logic               peak_ready,
  output logic [7:0]         peak_angle,
  output logic signed [12:0] peak_radius,
  output logic [35:0]        peak_votes,
  output logic [14:0]        peak_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int L  = MEM_LATENCY;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;
  state_t state;

  logic [7:0]         angle;
  logic signed [12:0] radius;
  logic [7:0]         next_angle;
  logic signed [12:0] next_radius;
  logic [35:0]        thr_q;
  logic [L:0]         tag_v;
  logic [7:0]         tag_a [L+1];
  logic [12:0]        tag_r [L+1];
  logic [56:0]        fifo_q [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [CW-1:0]      count;
  logic [15:0]        in_flight;
  logic [15:0]        free_cnt;
  logic               push;
  logic               pop;
  logic               can_issue;
  logic               last_bin;
  logic [18:0]        bin_addr;
`ifdef HOUGH_READER_CLEAR_EN
  logic               phase;
`endif

  always_comb begin
    in_flight = '0;
    for (int i = 0; i <= L; i++)
      in_flight = in_flight + 16'(tag_v[i]);
  end

  // Issue only while every in-flight read is guaranteed a free slot.
  assign free_cnt  = 16'(FIFO_DEPTH) - 16'(count);
  assign can_issue = free_cnt > in_flight;
  assign push      = tag_v[L] && (mem_read_data >= thr_q);
  assign peak_valid = (count != '0);
  assign pop       = peak_valid && peak_ready;
  assign last_bin  = (angle == 8'd176) && (radius == 13'sd800);
  assign bin_addr  = {4'b0, angle[7:2], radius[10:2]};
  assign mem_write_data = '0;
  assign {peak_angle, peak_radius, peak_votes} = fifo_q[rd_ptr];

  always_comb begin
    next_angle  = angle + 8'd4;
    next_radius = radius;
    if (angle == 8'd176) begin
      next_angle  = 8'd0;
      next_radius = radius + 13'sd4;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      mem_addr   <= '0;
      mem_we     <= 1'b0;
      angle      <= '0;
      radius     <= '0;
      thr_q      <= '0;
      tag_v      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      peak_count <= '0;
      for (int i = 0; i <= L; i++) begin
        tag_a[i] <= '0;
        tag_r[i] <= '0;
      end
      for (int i = 0; i < FIFO_DEPTH; i++)
        fifo_q[i] <= '0;
`ifdef HOUGH_READER_CLEAR_EN
      phase      <= 1'b0;
`endif
    end else begin
      done   <= 1'b0;
      mem_we <= 1'b0;
      tag_v  <= {tag_v[L-1:0], 1'b0};
      for (int i = L; i > 0; i--) begin
        tag_a[i] <= tag_a[i-1];
        tag_r[i] <= tag_r[i-1];
      end
      if (push) begin
        fifo_q[wr_ptr] <= {tag_a[L], tag_r[L], mem_read_data};
        wr_ptr <= wr_ptr + AW'(1);
        if (peak_count != 15'h7fff)
          peak_count <= peak_count + 15'd1;
      end
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);

      unique case (state)
        IDLE: begin
          if (start) begin
            state      <= SCAN;
            busy       <= 1'b1;
            thr_q      <= threshold;
            angle      <= 8'd0;
            radius     <= -13'sd800;
            peak_count <= '0;
`ifdef HOUGH_READER_CLEAR_EN
            phase      <= 1'b0;
`endif
          end
        end
        SCAN: begin
`ifdef HOUGH_READER_CLEAR_EN
          if (phase) begin
            mem_we <= 1'b1;
            phase  <= 1'b0;
            angle  <= next_angle;
            radius <= next_radius;
            if (last_bin)
              state <= DRAIN;
          end else if (can_issue) begin
            mem_addr <= bin_addr;
            tag_v[0] <= 1'b1;
            tag_a[0] <= angle;
            tag_r[0] <= radius;
            phase    <= 1'b1;
          end
`else
          if (can_issue) begin
            mem_addr <= bin_addr;
            tag_v[0] <= 1'b1;
            tag_a[0] <= angle;
            tag_r[0] <= radius;
            angle    <= next_angle;
            radius   <= next_radius;
            if (last_bin)
              state <= DRAIN;
          end
`endif
        end
        DRAIN: begin
          if (in_flight == 16'd0 && count == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hough_peak_reader.sv
// Directed bench for hough_peak_reader with a latency-matched ZBT memory model.
module tb_hough_peak_reader;
  localparam int FD    = 8;
  localparam int ML    = 2;
  localparam int NBINS = 18045;
`ifdef HOUGH_READER_CLEAR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  logic               clk;
  logic               reset;
  logic               start;
  logic [35:0]        threshold;
  logic               busy;
  logic               done;
  logic [18:0]        mem_addr;
  logic [35:0]        mem_read_data;
  logic [35:0]        mem_write_data;
  logic               mem_we;
  logic               peak_valid;
  logic               peak_ready;
  logic [7:0]         peak_angle;
  logic signed [12:0] peak_radius;
  logic [35:0]        peak_votes;
  logic [14:0]        peak_count;

  hough_peak_reader #(
    .FIFO_DEPTH (FD),
    .MEM_LATENCY(ML)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .threshold     (threshold),
    .busy          (busy),
    .done          (done),
    .mem_addr      (mem_addr),
    .mem_read_data (mem_read_data),
    .mem_write_data(mem_write_data),
    .mem_we        (mem_we),
    .peak_valid    (peak_valid),
    .peak_ready    (peak_ready),
    .peak_angle    (peak_angle),
    .peak_radius   (peak_radius),
    .peak_votes    (peak_votes),
    .peak_count    (peak_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [7:0]         a;
    logic signed [12:0] r;
    logic [35:0]        v;
  } peak_t;

  typedef struct {
    int          fill;
    logic [35:0] thr;
    int          rmode;
    int          exp_cnt;
  } vec_t;

  logic [35:0] mem [0:524287];
  logic [35:0] pipe [ML];
  peak_t got[$];
  peak_t exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, req);
    end
  endtask

  function automatic logic [18:0] baddr(input int a, input int r);
    logic [12:0] rr;
    logic [7:0]  aa;
    rr = 13'(r);
    aa = 8'(a);
    return {4'b0, aa[7:2], rr[10:2]};
  endfunction

  // One clock: memory samples address/we seen during the cycle.
  task automatic step();
    logic [18:0] a;
    logic        we;
    logic [35:0] wd;
    logic [35:0] rv;
    a  = mem_addr;
    we = mem_we;
    wd = mem_write_data;
    @(posedge clk);
    rv = mem[a];
    for (int i = ML - 1; i > 0; i--) pipe[i] = pipe[i-1];
    pipe[0] = rv;
    mem_read_data <= pipe[ML-1];
    if (we) mem[a] = wd;
    @(negedge clk);
  endtask

  task automatic fill(input int mode);
    for (int i = 0; i < 524288; i++) mem[i] = '0;
    for (int r = -800; r <= 800; r += 4) begin
      for (int a = 0; a <= 176; a += 4) begin
        if (mode == 2) mem[baddr(a, r)] = 36'd1;
        if (mode == 3) mem[baddr(a, r)] = 36'($urandom_range(0, 199));
      end
    end
    if (mode == 1) begin
      mem[baddr(0, -800)]  = 36'd5;
      mem[baddr(4, -800)]  = 36'd4;
      mem[baddr(88, 0)]    = 36'd7;
      mem[baddr(176, 800)] = 36'd9;
    end
  endtask

  task automatic build_expected(input logic [35:0] thr);
    peak_t p;
    exp_q.delete();
    for (int r = -800; r <= 800; r += 4) begin
      for (int a = 0; a <= 176; a += 4) begin
        if (mem[baddr(a, r)] >= thr) begin
          p.a = 8'(a);
          p.r = 13'(r);
          p.v = mem[baddr(a, r)];
          exp_q.push_back(p);
        end
      end
    end
  endtask

  task automatic run_scan(input logic [35:0] thr, input int rmode,
                          output int cycles);
    bit hold, seen, busy_d, pv_d, rdy, pw;
    int stab, wev, we_n;
    logic [7:0]         ha;
    logic signed [12:0] hr;
    logic [35:0]        hv;
    logic [18:0]        pa, held_addr;
    peak_t p;
    got.delete();
    hold = 0; seen = 0; busy_d = 0; pv_d = 0; pw = 0;
    stab = 0; wev = 0; we_n = 0; cycles = 0;
    ha = '0; hr = '0; hv = '0; pa = '0; held_addr = '0;
    threshold  = thr;
    start      = 1'b1;
    peak_ready = 1'b0;
    step();
    start     = 1'b0;
    threshold = ~thr;
    while (!seen && cycles < 60000) begin
      if (done) begin
        seen   = 1;
        busy_d = busy;
        pv_d   = peak_valid;
      end else begin
        case (rmode)
          0:       rdy = 1'b1;
          1:       rdy = 1'($urandom_range(0, 1));
          default: rdy = (cycles >= 300);
        endcase
        if (hold && (!peak_valid || peak_angle !== ha ||
                     peak_radius !== hr || peak_votes !== hv))
          stab++;
        if (peak_valid && rdy) begin
          p.a = peak_angle;
          p.r = peak_radius;
          p.v = peak_votes;
          got.push_back(p);
        end
        hold = peak_valid && !rdy;
        ha = peak_angle;
        hr = peak_radius;
        hv = peak_votes;
        if (mem_we) begin
          we_n++;
          if (!CLR || pw || mem_addr != pa) wev++;
        end
        if (mem_write_data != '0) wev++;
        pw = mem_we;
        pa = mem_addr;
        if (rmode == 2 && cycles == 250) held_addr = mem_addr;
        if (rmode == 2 && cycles == 299) begin
          chk("stall_count", peak_count, FD);
          chk("stall_addr", mem_addr, held_addr);
          chk("stall_valid", peak_valid, 1);
        end
        start      = (cycles == 500);
        peak_ready = rdy;
        step();
        cycles++;
      end
    end
    start      = 1'b0;
    peak_ready = 1'b1;
    chk("done_seen", seen, 1);
    chk("busy_at_done", busy_d, 0);
    chk("valid_at_done", pv_d, 0);
    chk("we_pattern", wev, 0);
    chk("we_count", we_n, CLR ? NBINS : 0);
    chk("stable_backpressure", stab, 0);
    step();
    chk("done_pulse", done, 0);
  endtask

  task automatic compare_stream();
    int mism;
    int n;
    mism = 0;
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      if (got[i].a !== exp_q[i].a || got[i].r !== exp_q[i].r ||
          got[i].v !== exp_q[i].v)
        mism++;
    end
    chk("stream_len", got.size(), exp_q.size());
    chk("stream_order", mism, 0);
  endtask

  initial begin
    vec_t tbl[4];
    int cyc;
    int bad;
    int nz;
    int ea[3];
    int er[3];
    int ev[3];
    tbl[0] = '{0, 36'd1, 0, 0};
    tbl[1] = '{1, 36'd5, 0, 3};
    tbl[2] = '{2, 36'd1, 2, NBINS};
    tbl[3] = '{3, 36'd100, 1, -1};
    ea = '{0, 88, 176};
    er = '{-800, 0, 800};
    ev = '{5, 7, 9};

    reset = 1'b1;
    start = 1'b0;
    threshold = '0;
    peak_ready = 1'b0;
    mem_read_data = '0;
    for (int i = 0; i < ML; i++) pipe[i] = '0;
    @(negedge clk);
    repeat (3) step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", peak_valid, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_count", peak_count, 0);
    chk("rst_angle", peak_angle, 0);
    chk("rst_radius", peak_radius, 0);
    chk("rst_votes", peak_votes, 0);
    chk("rst_wdata", mem_write_data, 0);
    reset = 1'b0;
    step();

    for (int i = 0; i < 4; i++) begin
`ifdef HOUGH_READER_CLEAR_EN
      if (i == 0 || i == 2) continue;
`endif
      fill(tbl[i].fill);
      build_expected(tbl[i].thr);
      run_scan(tbl[i].thr, tbl[i].rmode, cyc);
      chk("peak_count", peak_count,
          tbl[i].exp_cnt < 0 ? exp_q.size() : tbl[i].exp_cnt);
      compare_stream();
      if (i == 0)
        chk("done_latency",
            (cyc >= NBINS + ML) && (cyc <= NBINS + ML + 4), 1);
      if (i == 1 && got.size() >= 3) begin
        for (int k = 0; k < 3; k++) begin
          chk("peak_angle", got[k].a, ea[k]);
          chk("peak_radius", got[k].r, er[k]);
          chk("peak_votes", got[k].v, ev[k]);
        end
      end
`ifdef HOUGH_READER_CLEAR_EN
      nz = 0;
      for (int r = -800; r <= 800; r += 4)
        for (int a = 0; a <= 176; a += 4)
          if (mem[baddr(a, r)] != '0) nz++;
      chk("cleared", nz, 0);
`endif
    end

    // Reset in the middle of a scan, then rescan from the first bin.
    fill(2);
    threshold = 36'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    peak_ready = 1'b1;
    for (int k = 0; k < (CLR ? 2000 : 1000); k++) step();
    chk("mid_busy", busy, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", peak_valid, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_addr", mem_addr, 0);
    chk("mid_rst_we", mem_we, 0);
    chk("mid_rst_count", peak_count, 0);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      if (done || peak_valid || busy) bad++;
      step();
    end
    chk("quiet_after_reset", bad, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("rescan_first", mem_addr, baddr(0, -800));
    for (int k = 0; k < 4; k++)
      if (mem_addr == baddr(0, -800)) step();
    chk("rescan_second", mem_addr, baddr(4, -800));
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hough_peak_reader.md
HOUGH_PEAK_READER -- requirements
Module: hough_peak_reader

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, output peak FIFO entries (power of two, >=4).
REQ-002 SHALL have parameter MEM_LATENCY, default 2, clock edges from address presented to mem_read_data valid.
REQ-003 SHALL have ports: clk input 1, sole clock; reset input 1, synchronous active-high.
REQ-004 SHALL have ports: start input 1, one-cycle pulse begins scan; threshold input 36, minimum vote count to report.
REQ-005 SHALL have ports: busy output 1, scan in progress; done output 1, one-cycle pulse at scan completion.
REQ-006 SHALL have ports: mem_addr output 19, ZBT address; mem_read_data input 36; mem_write_data output 36; mem_we output 1.
REQ-007 SHALL have ports: peak_valid output 1; peak_ready input 1; peak_angle output 8, degrees; peak_radius output 13 signed, pixels; peak_votes output 36.
REQ-008 SHALL have port peak_count output 15, peaks pushed this scan.

Function
REQ-009 SHALL read the accumulator the voter writes: mem_addr = {4'b0, angle[7:2], radius[10:2]}, radius two's complement.
REQ-010 SHALL scan radius outer -800..800 step 4, angle inner 0..176 step 4; 401x45 = 18045 bins, no others.
REQ-011 SHALL latch threshold on start; later changes ignored until next start.
REQ-012 SHALL use states IDLE -> SCAN (issue reads) -> DRAIN (in-flight reads return, FIFO empties) -> IDLE.
REQ-013 SHALL tag each issued read with angle/radius through a MEM_LATENCY-deep pipeline, aligning tag with returned data.
REQ-014 SHALL push {angle, radius, votes} into the FIFO when returned votes >= latched threshold (unsigned 36-bit compare).
REQ-015 SHALL stall issuing reads (hold mem_addr, mem_we=0) while FIFO free entries <= in-flight reads, so no push is ever lost.
REQ-016 SHALL present FIFO head on peak_* with peak_valid; pop on peak_valid & peak_ready; push and pop in the same cycle allowed, including at full.
REQ-017 SHALL keep peak_* stable while peak_valid=1 and peak_ready=0.
REQ-018 SHALL emit peaks in scan order.
REQ-019 SHALL increment peak_count per push, saturating at 32767; cleared on start.
REQ-020 SHALL pulse done for one cycle when last read returned and FIFO empty; busy deasserts same cycle.
REQ-021 SHALL ignore start while busy=1.
REQ-022 SHALL with threshold 0 report every bin.
REQ-023 SHALL drive mem_write_data = 0 always.

Reset
REQ-024 SHALL on reset, regardless of state: IDLE, FIFO and pipeline flushed, busy=0, done=0, peak_valid=0, mem_we=0, mem_addr=0, peak_count=0.
REQ-025 SHALL on reset mid-scan produce no done pulse and no further peaks.
REQ-026 SHALL reset peak_angle=0, peak_radius=0, peak_votes=0.

Configuration
REQ-027 SHALL, with HOUGH_READER_CLEAR_EN defined, clear bins after reading: cycle 2k mem_addr=A_k, mem_we=0; cycle 2k+1 mem_addr=A_k, mem_we=1, write 0; scan takes 2x cycles; stall only on even cycles.
REQ-028 SHALL, without HOUGH_READER_CLEAR_EN, keep mem_we=0 always, one read per cycle when not stalled.

Verification
REQ-029 SHALL cover: memory model all-zero, threshold 1 -> no peak_valid, peak_count=0, done after 18045+MEM_LATENCY issue cycles (macro off).
REQ-030 SHALL cover: bins (angle 0, r -800)=5, (angle 176, r 800)=9, (angle 88, r 0)=7, threshold 5 -> peaks (0,-800,5),(88,0,7),(176,800,9) in order, peak_count=3.
REQ-031 SHALL cover: all bins=1, threshold 1, peak_ready held 0 -> after FIFO_DEPTH pushes reads stall, no peak lost; release -> 18045 peaks total, count saturates not.
REQ-032 SHALL cover: random peak_ready toggling, 50% bins above threshold -> output stream equals reference list; peak_* stable under backpressure.
REQ-033 SHALL cover: reset asserted at bin 1000 -> next cycle busy=0, peak_valid=0, no done; new start rescans from (0,-800).
REQ-034 SHALL cover: HOUGH_READER_CLEAR_EN defined, bins nonzero -> peaks reported once, model all-zero after done, mem_we alternates 0/1.
